calc_op_responder: RTL

//  Sequential, handshaked responder for calculator operation requests (a, b, oper).
//  - Accepts one request at a time over a valid/ready request channel.
//  - Computes the result: single-cycle datapath for add/sub/logic; shift-add for

---
 rtl/calc_op_responder_if.sv | 37 +++
 rtl/calc_op_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/calc_op_responder_if.sv
// calc_op_responder_if
//  Request/response bundle between an operation initiator and calc_op_responder.
//  Request : req_valid, req_ready, a, b, oper
//  Response: rsp_valid, rsp_ready, out, rsp_err (rsp_err only with CALC_DIV0_ERR_EN)
//  Modports: master = initiator side, slave = responder side.
//  Optional feature macro: CALC_DIV0_ERR_EN
interface calc_op_responder_if #(
  parameter int W = 4
);
  logic           req_valid;
  logic           req_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     oper;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2*W-1:0] out;
`ifdef CALC_DIV0_ERR_EN
  logic           rsp_err;
`endif

  modport master (
    output req_valid, a, b, oper, rsp_ready,
`ifdef CALC_DIV0_ERR_EN
    input  rsp_err,
`endif
    input  req_ready, rsp_valid, out
  );

  modport slave (
    input  req_valid, a, b, oper, rsp_ready,
`ifdef CALC_DIV0_ERR_EN
    output rsp_err,
`endif
    output req_ready, rsp_valid, out
  );
endinterface

// File: rtl/calc_op_responder.sv
// calc_op_responder
//  Sequential valid/ready calculator. One request in flight at a time:
//  IDLE accepts (a, b, oper), CALC computes, DONE presents the 2W-bit result
//  until the consumer takes it.
//  add/sub/and/or/xor finish in one CALC cycle; mul (shift-add) and div/mod
//  (restoring division) take exactly W CALC cycles, one operand bit per cycle,
//  walking bit W-1 down to 0.
//  Ports:
//    clk  - rising-edge clock
//    rst  - asynchronous active-high reset, discards any in-flight operation
//    bus  - calc_op_responder_if.slave (request + response channels)
//  Optional feature macro: CALC_DIV0_ERR_EN adds rsp_err, set for div/mod by 0.
module calc_op_responder #(
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  calc_op_responder_if.slave   bus
);
  localparam int CW = $clog2(W);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_MOD = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2:0]     r_op;
  logic [CW-1:0]  r_cnt;
  logic [2*W-1:0] r_acc;   // multiply accumulator
  logic [W-1:0]   r_rem;   // division partial remainder
  logic [W-1:0]   r_q;     // division quotient bits
  logic [2*W-1:0] r_out;
  logic           r_req_ready;
  logic           r_rsp_valid;
`ifdef CALC_DIV0_ERR_EN
  logic           r_err;
`endif

  logic [2*W-1:0] w_a_ext;
  logic [2*W-1:0] w_b_ext;
  logic [2*W-1:0] w_simple;
  logic [2*W-1:0] w_mul_nxt;
  logic [W:0]     w_rem_sh;
  logic           w_ge;
  logic [W-1:0]   w_rem_nxt;
  logic [W-1:0]   w_q_nxt;
  logic           w_iter;
  logic           w_div0;
  logic [2*W-1:0] w_iter_res;

  assign w_a_ext = {{W{1'b0}}, r_a};
  assign w_b_ext = {{W{1'b0}}, r_b};
  assign w_iter  = (r_op == OP_MUL) || (r_op == OP_DIV) || (r_op == OP_MOD);
  assign w_div0  = (r_b == '0);

  // Single-cycle results; sub wraps modulo 2^(2W) naturally.
  always_comb begin
    w_simple = '0;
    case (r_op)
      OP_ADD:  w_simple = w_a_ext + w_b_ext;
      OP_SUB:  w_simple = w_a_ext - w_b_ext;
      OP_AND:  w_simple = w_a_ext & w_b_ext;
      OP_OR:   w_simple = w_a_ext | w_b_ext;
      OP_XOR:  w_simple = w_a_ext ^ w_b_ext;
      default: w_simple = '0;
    endcase
  end

  // MSB-first shift-add: acc = 2*acc + (b[i] ? a : 0).
  assign w_mul_nxt = (r_acc << 1) + (r_b[r_cnt] ? w_a_ext : '0);

  // Restoring division step: bring down a[i], subtract b when it fits.
  // With b=0 every step "fits", so rem accumulates a and the quotient is all ones.
  assign w_rem_sh  = {r_rem, r_a[r_cnt]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_b});
  assign w_rem_nxt = w_ge ? W'(w_rem_sh - {1'b0, r_b}) : w_rem_sh[W-1:0];
  assign w_q_nxt   = r_q | ({{(W-1){1'b0}}, w_ge} << r_cnt);

  // Result on the final iteration; divide-by-zero quotient saturates to all ones.
  always_comb begin
    w_iter_res = '0;
    case (r_op)
      OP_MUL:  w_iter_res = w_mul_nxt;
      OP_DIV:  w_iter_res = w_div0 ? '1 : {{W{1'b0}}, w_q_nxt};
      OP_MOD:  w_iter_res = {{W{1'b0}}, w_rem_nxt};
      default: w_iter_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_q         <= '0;
      r_out       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
`ifdef CALC_DIV0_ERR_EN
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_a         <= bus.a;
            r_b         <= bus.b;
            r_op        <= bus.oper;
            r_cnt       <= CW'(W-1);
            r_acc       <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_req_ready <= 1'b0;
            r_state     <= CALC;
          end
        end
        CALC: begin
          if (!w_iter) begin
            r_out       <= w_simple;
            r_rsp_valid <= 1'b1;
`ifdef CALC_DIV0_ERR_EN
            r_err       <= 1'b0;
`endif
            r_state     <= DONE;
          end else begin
            r_acc <= w_mul_nxt;
            r_rem <= w_rem_nxt;
            r_q   <= w_q_nxt;
            if (r_cnt == '0) begin
              r_out       <= w_iter_res;
              r_rsp_valid <= 1'b1;
`ifdef CALC_DIV0_ERR_EN
              r_err       <= (r_op != OP_MUL) && w_div0;
`endif
              r_state     <= DONE;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
        end
        DONE: begin
          // No same-cycle bypass: req_ready only rises the cycle after the take.
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.out       = r_out;
`ifdef CALC_DIV0_ERR_EN
  assign bus.rsp_err   = r_err;
`endif

endmodule
